// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - 1-to-NCH stream demux with one-entry registered buffer per channel
// Optional per-channel saturating beat counters: define DEMUX_STREAM_CNT_EN.
module demux_stream #(
  parameter int DW  = 8,
  parameter int NCH = 4,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SELW-1:0]   in_sel,
  input  logic [DW-1:0]     in_data,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
`ifdef DEMUX_STREAM_CNT_EN
  output logic [NCH*16-1:0] beat_cnt,
`endif
  output logic              drop
);

  localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

  logic [NCH-1:0]    r_valid;
  logic [NCH*DW-1:0] r_data;
  logic              r_drop;

  logic              w_sel_ok;
  logic              w_tgt_free;
  logic              w_accept;
  logic [NCH-1:0]    w_hit;
  logic [NCH-1:0]    w_push;

  assign w_sel_ok = ({1'b0, in_sel} < NCH_W);

  // Out-of-range selects match no channel, so they are always free to accept (and drop).
  always_comb begin
    w_tgt_free = 1'b1;
    w_hit      = '0;
    for (int k = 0; k < NCH; k++) begin
      if (in_sel == SELW'(k)) begin
        w_hit[k]   = 1'b1;
        w_tgt_free = !r_valid[k] || out_ready[k];
      end
    end
  end

  assign in_ready = en && w_tgt_free;
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_hit & {NCH{w_accept}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_accept && !w_sel_ok;
      for (int k = 0; k < NCH; k++) begin
        if (w_push[k]) begin
          r_valid[k]          <= 1'b1;
          r_data[k*DW +: DW]  <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign drop      = r_drop;

`ifdef DEMUX_STREAM_CNT_EN
  logic [NCH*16-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_push[k] && r_cnt[k*16 +: 16] != 16'hFFFF) begin
          r_cnt[k*16 +: 16] <= r_cnt[k*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign beat_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb/tb_demux_stream.sv - bench for demux_stream: NCH=4 and NCH=3 instances against a queue model
// Counter checks are active when DEMUX_STREAM_CNT_EN is defined.
module tb_demux_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] en_v, iv_v, ir_v, drop_v;
  logic [1:0] sel_v [2];
  logic [7:0] din_v [2];
  logic [3:0] or_v  [2];
  logic [3:0] ov_v  [2];
  logic [31:0] od_v [2];

  logic [3:0]  ov4;
  logic [31:0] od4;
  logic [2:0]  ov3;
  logic [23:0] od3;
  assign ov_v[0] = ov4;
  assign od_v[0] = od4;
  assign ov_v[1] = {1'b0, ov3};
  assign od_v[1] = {8'h00, od3};

`ifdef DEMUX_STREAM_CNT_EN
  logic [63:0] bc4;
  logic [47:0] bc3;
`endif

  demux_stream #(.DW(8), .NCH(4)) u4 (
    .clk(clk), .rst(rst), .en(en_v[0]), .in_valid(iv_v[0]), .in_ready(ir_v[0]),
    .in_sel(sel_v[0]), .in_data(din_v[0]), .out_valid(ov4), .out_ready(or_v[0]),
    .out_data(od4),
`ifdef DEMUX_STREAM_CNT_EN
    .beat_cnt(bc4),
`endif
    .drop(drop_v[0])
  );

  demux_stream #(.DW(8), .NCH(3)) u3 (
    .clk(clk), .rst(rst), .en(en_v[1]), .in_valid(iv_v[1]), .in_ready(ir_v[1]),
    .in_sel(sel_v[1]), .in_data(din_v[1]), .out_valid(ov3), .out_ready(or_v[1][2:0]),
    .out_data(od3),
`ifdef DEMUX_STREAM_CNT_EN
    .beat_cnt(bc3),
`endif
    .drop(drop_v[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: each channel is a depth-1 FIFO; data output shows the head, or the last beat once drained.
  logic [7:0] mq    [2][4][$];
  logic [7:0] mlast [2][4];
  logic       mdrop [2];
  int         mcnt  [2][4];

  function automatic int nchs(int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic logic exp_ready(int d);
    int s;
    s = int'(sel_v[d]);
    if (!en_v[d]) return 1'b0;
    if (s >= nchs(d)) return 1'b1;
    return (mq[d][s].size() == 0) || or_v[d][s];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mdrop[d] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          mq[d][k].delete();
          mlast[d][k] = 8'h00;
          mcnt[d][k]  = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic acc;
        int   s;
        s   = int'(sel_v[d]);
        acc = iv_v[d] && exp_ready(d);
        for (int k = 0; k < nchs(d); k++)
          if (mq[d][k].size() != 0 && or_v[d][k]) void'(mq[d][k].pop_front());
        mdrop[d] = acc && (s >= nchs(d));
        if (acc && s < nchs(d)) begin
          mq[d][s].push_back(din_v[d]);
          mlast[d][s] = din_v[d];
          if (mcnt[d][s] < 65535) mcnt[d][s]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk("in_ready", 32'(ir_v[d]), 32'(exp_ready(d)));
        chk("drop", 32'(drop_v[d]), 32'(mdrop[d]));
        for (int k = 0; k < nchs(d); k++) begin
          chk("out_valid", 32'(ov_v[d][k]), 32'(mq[d][k].size() != 0));
          chk("out_data", 32'(od_v[d][k*8 +: 8]),
              32'((mq[d][k].size() != 0) ? mq[d][k][0] : mlast[d][k]));
`ifdef DEMUX_STREAM_CNT_EN
          chk("beat_cnt", (d == 0) ? 32'(bc4[k*16 +: 16]) : 32'(bc3[k*16 +: 16]), 32'(mcnt[d][k]));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(int d, logic v, int s, logic [7:0] data);
    iv_v[d]  = v;
    sel_v[d] = 2'(s);
    din_v[d] = data;
  endtask

  initial begin
    rst = 1'b1;
    en_v = 2'b11;
    iv_v = 2'b00;
    for (int d = 0; d < 2; d++) begin
      sel_v[d] = 2'd0;
      din_v[d] = 8'h00;
      or_v[d]  = 4'hF;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", 32'(ov_v[d]), 32'h0);
      chk("rst_out_data", od_v[d], 32'h0);
      chk("rst_drop", 32'(drop_v[d]), 32'h0);
    end
    tick();
    rst = 1'b0;

    // One-hot routing sweep at full rate
    for (int i = 0; i < 4; i++) begin
      put(0, 1'b1, i, 8'hA0 + 8'(i));
      @(negedge clk);
      chk("t1_in_ready", 32'(ir_v[0]), 32'h1);
      chk("t1_out_valid", 32'(ov_v[0]), (i == 0) ? 32'h0 : (32'h1 << (i - 1)));
      if (i > 0) chk("t1_out_data", 32'(od_v[0][(i-1)*8 +: 8]), 32'hA0 + 32'(i - 1));
      tick();
    end
    put(0, 1'b0, 0, 8'h00);
    @(negedge clk);
    chk("t1_out_valid_last", 32'(ov_v[0]), 32'h8);
    chk("t1_out_data_last", 32'(od_v[0][31:24]), 32'hA3);
    chk("pin_model_last3", 32'(mlast[0][3]), 32'hA3);
    tick();

    // Stall on a full channel, then reload on the same edge as the pop
    or_v[0] = 4'b1011;
    put(0, 1'b1, 2, 8'h55);
    tick();
    put(0, 1'b1, 2, 8'h66);
    @(negedge clk);
    chk("t2_stall_ready", 32'(ir_v[0]), 32'h0);
    chk("t2_held_data", 32'(od_v[0][23:16]), 32'h55);
    tick();
    @(negedge clk);
    chk("t2_still_held", 32'(od_v[0][23:16]), 32'h55);
    tick();
    or_v[0] = 4'hF;
    @(negedge clk);
    chk("t2_release_ready", 32'(ir_v[0]), 32'h1);
    tick();
    put(0, 1'b0, 0, 8'h00);
    @(negedge clk);
    chk("t2_reload_valid", 32'(ov_v[0][2]), 32'h1);
    chk("t2_reload_data", 32'(od_v[0][23:16]), 32'h66);
    tick();
    @(negedge clk);
    chk("t2_drained", 32'(ov_v[0][2]), 32'h0);
    chk("t2_data_kept", 32'(od_v[0][23:16]), 32'h66);
    tick();

    // Blocked channel 1 while channels 0/3 drain independently
    or_v[0] = 4'b0000;
    put(0, 1'b1, 1, 8'h11); tick();
    put(0, 1'b1, 0, 8'h22); tick();
    put(0, 1'b1, 3, 8'h33); tick();
    put(0, 1'b1, 1, 8'h44);
    @(negedge clk);
    chk("t3_stall_ready", 32'(ir_v[0]), 32'h0);
    chk("t3_full", 32'(ov_v[0]), 32'hB);
    tick();
    or_v[0] = 4'b1001;
    tick();
    @(negedge clk);
    chk("t3_side_pops", 32'(ov_v[0]), 32'h2);
    chk("t3_ch1_held", 32'(od_v[0][15:8]), 32'h11);
    tick();
    or_v[0] = 4'hF;
    tick();
    put(0, 1'b1, 3, 8'h77);
    @(negedge clk);
    chk("t3_ch1_new", 32'(od_v[0][15:8]), 32'h44);
    tick();
    put(0, 1'b0, 0, 8'h00);
    @(negedge clk);
    chk("t3_ch3_delivered", 32'(ov_v[0]), 32'h8);
    chk("t3_ch3_data", 32'(od_v[0][31:24]), 32'h77);
    tick();

    // Out-of-range select on the 3-channel instance
    put(1, 1'b1, 3, 8'hFF);
    @(negedge clk);
    chk("t4_ready", 32'(ir_v[1]), 32'h1);
    tick();
    put(1, 1'b0, 0, 8'h00);
    @(negedge clk);
    chk("t4_drop", 32'(drop_v[1]), 32'h1);
    chk("t4_no_valid", 32'(ov_v[1]), 32'h0);
    tick();
    @(negedge clk);
    chk("t4_drop_clear", 32'(drop_v[1]), 32'h0);
    tick();

    // Enable low blocks acceptance while a buffered beat drains
    or_v[0] = 4'b1110;
    put(0, 1'b1, 0, 8'h5A);
    tick();
    en_v[0] = 1'b0;
    or_v[0] = 4'hF;
    put(0, 1'b1, 0, 8'hA5);
    @(negedge clk);
    chk("t5_ready_low", 32'(ir_v[0]), 32'h0);
    chk("t5_preloaded", 32'(ov_v[0]), 32'h1);
    tick();
    @(negedge clk);
    chk("t5_drained", 32'(ov_v[0]), 32'h0);
    chk("t5_no_accept_data", 32'(od_v[0][7:0]), 32'h5A);
    tick();
    en_v[0] = 1'b1;
    put(0, 1'b0, 0, 8'h00);

    // Random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 2; d++) begin
        en_v[d] = ($urandom_range(0, 9) != 0);
        put(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 8'($urandom));
        or_v[d] = 4'($urandom);
      end
      tick();
    end

    // Reset mid-stream with channels full
    en_v = 2'b11;
    or_v[0] = 4'h0;
    or_v[1] = 4'h0;
    put(0, 1'b1, 0, 8'hC1); put(1, 1'b1, 0, 8'hD1); tick();
    put(0, 1'b1, 1, 8'hC2); put(1, 1'b1, 1, 8'hD2); tick();
    put(0, 1'b0, 0, 8'h00); put(1, 1'b0, 0, 8'h00);
    @(negedge clk);
    chk("t6_pre_full", 32'(ov_v[0]), 32'h3);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t6_rst_valid", 32'(ov_v[d]), 32'h0);
      chk("t6_rst_data", od_v[d], 32'h0);
      chk("t6_rst_drop", 32'(drop_v[d]), 32'h0);
    end
    tick();
    rst = 1'b0;
    or_v[0] = 4'hF;
    or_v[1] = 4'hF;

`ifdef DEMUX_STREAM_CNT_EN
    @(negedge clk);
    chk("t7_cnt_zero", bc4[31:0], 32'h0);
    tick();
    for (int c = 0; c < 65540; c++) begin
      put(0, 1'b1, 0, 8'($urandom));
      tick();
    end
    put(0, 1'b0, 0, 8'h00);
    @(negedge clk);
    chk("t7_cnt_sat", 32'(bc4[15:0]), 32'hFFFF);
    chk("pin_model_sat", 32'(mcnt[0][0]), 32'hFFFF);
    tick();
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- Parametrised 1-to-NCH stream demultiplexer; successor to the combinational 1:4 demux.
- Single input stream with per-beat channel select; routes each beat to one of NCH output channels.
- Each output channel has a one-entry registered buffer with valid/ready handshake, so back-pressure on one channel does not corrupt others.
- Sits between a packet/beat source and NCH independent consumers.

Parameters:
- DW, 8, data width per beat (>=1).
- NCH, 4, number of output channels (>=2; need not be a power of 2).
- SELW, $clog2(NCH), select width; derived, not overridden.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; low blocks new input acceptance.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_sel  input  SELW  destination channel of current beat.
- in_data  input  DW  input beat data.
- out_valid  output  NCH  per-channel buffer valid.
- out_ready  input  NCH  per-channel consumer ready.
- out_data  output  NCH*DW  channel k data at bits [k*DW +: DW].
- drop  output  1  one-cycle pulse: a beat with out-of-range in_sel was accepted and discarded.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, drop=0; all buffered beats lost.
- Channel k pop: out_valid[k] && out_ready[k] at a rising edge.
- in_ready (combinational): en && (in_sel >= NCH || !out_valid[in_sel] || out_ready[in_sel]).
- Combinational path out_ready -> in_ready is permitted and required for full throughput.
- Accept with in_sel < NCH: next edge out_data[sel] <= in_data and out_valid[sel] <= 1. Latency is 1 cycle from acceptance to out_valid.
- Accept with in_sel >= NCH: beat discarded, no channel changes, drop=1 for the following cycle only.
- Same-channel push and pop in one cycle: buffer reloaded with new beat, out_valid stays 1. Sustains 1 beat/cycle per channel.
- Pop without push: out_valid[k] <= 0. out_data[k] holds its last value (not cleared).
- Channels not selected hold state; their pops proceed independently in the same cycle.
- en low: in_ready=0, no acceptance. Pending channel buffers still drain via out_ready. drop deasserts.
- in_valid low: in_ready still computed as above; nothing accepted.
- Upstream must hold in_data/in_sel stable while in_valid && !in_ready. Block does not check this.
- rst mid-transfer: all outputs return to reset values immediately; buffered beats are discarded.

Optional Feature:
- Macro: DEMUX_STREAM_CNT_EN.
- Defined: extra output port beat_cnt, NCH*16 bits.
  - Channel k count at [k*16 +: 16].
  - Increments on each accepted beat to channel k.
  - Saturates at 16'hFFFF.
  - Reset to 0 by rst.
  - Dropped beats are not counted.
- Undefined: beat_cnt port and counters absent. All other behaviour identical.

Test Plan:
- Reset, then NCH=4, all out_ready=1, stream sel 0,1,2,3 with data 8'hA0..8'hA3 → out_valid one-hot 0001,0010,0100,1000 on consecutive cycles, each 1 cycle after accept; out_data matches; in_ready constant 1.
- Channel 2 out_ready=0, send sel=2 data 8'h55, then sel=2 data 8'h66 → second beat stalls (in_ready=0), out_data[2]=8'h55 held; raise out_ready[2] → 8'h66 loads in the same edge as 8'h55 pops, out_valid[2] stays 1.
- Channel 1 blocked with full buffer, send sel=1 then sel=3 → sel=1 stalls; after it drains, sel=3 beat is delivered; channel 0/3 pops during the stall unaffected.
- NCH=3, send sel=3 data 8'hFF → in_ready=1, no out_valid change, drop=1 for exactly one cycle.
- en=0 with in_valid=1, sel=0 → in_ready=0 and no acceptance, while a pre-loaded channel 0 beat still pops.
- Assert rst mid-stream with 2 channels full → out_valid=0, out_data=0 immediately; with DEMUX_STREAM_CNT_EN, beat_cnt=0 and counts match accepted beats after release; a 65540-beat run on channel 0 reads 16'hFFFF.
